input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 Parameter DB_CYCLES, default 1000: consecutive stable cycles required to accept a level change; legal range 2..65535.
REQ-003 Parameter HOLDOFF_CYCLES, default 16: coin lockout length after an accepted coin; legal range 1..65535.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 L_button  in  1  raw asynchronous left button.
REQ-007 R_button  in  1  raw asynchronous right button.
REQ-008 C_button  in  1  raw asynchronous confirm button.
REQ-009 switch  in  4  raw asynchronous coin switches; bits 0..3 denote coins of 1, 5, 10, 20.
REQ-010 L_pulse  out  1  one-cycle strobe for an accepted left press.
REQ-011 R_pulse  out  1  one-cycle strobe for an accepted right press.
REQ-012 C_pulse  out  1  one-cycle strobe for an accepted confirm press.
REQ-013 coin_valid  out  1  one-cycle strobe for an accepted coin.
REQ-014 coin_value  out  5  coin value (1/5/10/20), valid only while coin_valid=1, else 0.

Function
REQ-015 Each of the 7 raw inputs SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-016 Each input SHALL have its own debouncer with a registered stable level and a 16-bit counter.
REQ-017 The counter SHALL clear whenever the synchronized sample equals the stable level.
REQ-018 The counter SHALL increment on each cycle the synchronized sample differs from the stable level.
REQ-019 On the cycle the count would reach DB_CYCLES, the stable level SHALL toggle and the counter SHALL clear.
REQ-020 A raw change held for fewer than DB_CYCLES synchronized cycles SHALL leave the stable level unchanged.
REQ-021 Only a stable 0->1 transition SHALL produce an event; stable 1->0 transitions SHALL produce no output.
REQ-022 An event SHALL appear as a registered one-cycle output first high on the (DB_CYCLES+3)th rising edge after the raw change (7 for DB_CYCLES=4).
REQ-023 A held input SHALL produce exactly one event per press, regardless of hold time.
REQ-024 If L and R stable rising transitions occur in the same cycle, neither L_pulse nor R_pulse SHALL assert.
REQ-025 C_pulse SHALL be independent of L and R.
REQ-026 The coin path SHALL be a two-state FSM with states READY and HOLDOFF.
REQ-027 In READY, any coin rising event SHALL assert coin_valid for one cycle, load the holdoff counter with HOLDOFF_CYCLES, and move the FSM to HOLDOFF.
REQ-028 When several coin rising events occur in the same cycle, the highest-index switch SHALL win and the others SHALL be discarded.
REQ-029 In HOLDOFF, the counter SHALL decrement each cycle and return the FSM to READY on the cycle it reaches 0.
REQ-030 Coin rising events occurring in HOLDOFF SHALL be discarded, not queued.
REQ-031 Coin and button outputs MAY assert in the same cycle.

Reset
REQ-032 While rst=1, synchronizers, stable levels, debounce counters, holdoff counter and all outputs SHALL be 0, and the coin FSM SHALL be READY.
REQ-033 rst asserted mid-debounce SHALL abort the debounce with no pulse.
REQ-034 An input still high after reset release SHALL be treated as a new press and pulse DB_CYCLES+3 edges after release.
REQ-035 Reset SHALL take precedence over all other activity in the same cycle.

Verification (DB_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-036 switch[2] raised and held 20 cycles -> coin_valid=1, coin_value=10 on edge 7 for exactly one cycle, then nothing further.
REQ-037 L_button high for 3 cycles then low -> no L_pulse ever asserts.
REQ-038 switch[0] and switch[3] rise together -> single coin_valid with coin_value=20.
REQ-039 switch[1] accepted, then switch[0] rising event 3 cycles later -> discarded; switch[0] rising event 12 cycles after the first coin -> coin_value=1.
REQ-040 L_button and R_button rise together, C_button with them -> no L_pulse or R_pulse; C_pulse on edge 7.
REQ-041 C_button raised, rst pulsed at edge 4 with C_button then released low -> no C_pulse; all outputs 0 during reset.

Source files
------------

// File: rtl/input_conditioner.sv
// Button and coin-switch front end: synchronize, debounce, and turn
// accepted rising edges into one-cycle strobes with coin lockout.
module input_conditioner #(
   parameter int DB_CYCLES      = 1000,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       L_button,
   input  logic       R_button,
   input  logic       C_button,
   input  logic [3:0] switch,
   output logic       L_pulse,
   output logic       R_pulse,
   output logic       C_pulse,
   output logic       coin_valid,
   output logic [4:0] coin_value
);

   localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
   localparam logic [15:0] HO_LOAD = 16'(HOLDOFF_CYCLES);
   localparam logic [0:0]  ST_READY = 1'b0;
   localparam logic [0:0]  ST_HOLD  = 1'b1;

   logic [6:0] raw_w;
   logic [6:0] rise_w;

   assign raw_w = {switch, C_button, R_button, L_button};

   for (genvar i = 0; i < 7; i++) begin : g_ch
      logic        s1_q, s2_q;
      logic        stab_q, stab_d;
      logic        rise_q, rise_d;
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d  = cnt_q;
         stab_d = stab_q;
         rise_d = 1'b0;
         if (s2_q == stab_q) begin
            cnt_d = '0;
         end else if (cnt_q == DB_LAST) begin
            cnt_d  = '0;
            stab_d = ~stab_q;
            rise_d = ~stab_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            stab_q <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            s1_q   <= raw_w[i];
            s2_q   <= s1_q;
            stab_q <= stab_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
         end
      end

      assign rise_w[i] = rise_q;
   end

   logic [0:0]  state_q, state_d;
   logic [15:0] ho_q, ho_d;
   logic        l_q, l_d, r_q, r_d, c_q, c_d;
   logic        cv_q, cv_d;
   logic [4:0]  val_q, val_d, sel_w;

   // Highest-index coin wins when several land together.
   always_comb begin
      sel_w = 5'd0;
      if (rise_w[6])      sel_w = 5'd20;
      else if (rise_w[5]) sel_w = 5'd10;
      else if (rise_w[4]) sel_w = 5'd5;
      else if (rise_w[3]) sel_w = 5'd1;
   end

   always_comb begin
      state_d = state_q;
      ho_d    = ho_q;
      cv_d    = 1'b0;
      val_d   = 5'd0;
      l_d     = rise_w[0] & ~rise_w[1];
      r_d     = rise_w[1] & ~rise_w[0];
      c_d     = rise_w[2];
      case (state_q)
         ST_READY: begin
            if (|rise_w[6:3]) begin
               cv_d    = 1'b1;
               val_d   = sel_w;
               ho_d    = HO_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            ho_d = ho_q - 16'd1;
            if (ho_d == 16'd0) state_d = ST_READY;
         end
         default: state_d = ST_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_READY;
         ho_q    <= '0;
         l_q     <= 1'b0;
         r_q     <= 1'b0;
         c_q     <= 1'b0;
         cv_q    <= 1'b0;
         val_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         ho_q    <= ho_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cv_q    <= cv_d;
         val_q   <= val_d;
      end
   end

   assign L_pulse    = l_q;
   assign R_pulse    = r_q;
   assign C_pulse    = c_q;
   assign coin_valid = cv_q;
   assign coin_value = val_q;

endmodule
